// File: rtl/concatenador_multi.sv
// Multi-lane block assembler: builds {header, nonce} blocks for staggered hash lanes
// and drives the shared phase counter for the hash cores.
module concatenador_multi #(
  parameter int HEADER_W = 96,
  parameter int NONCE_W  = 32,
  parameter int LANES    = 2,
  parameter int PERIOD   = 64,
  parameter int STAGGER  = 2,
  parameter int CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset_L,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic [HEADER_W-1:0]                    header,
  input  logic [NONCE_W-1:0]                     nonce_base,
  input  logic [NONCE_W-1:0]                     nonce_last,
  output logic [LANES*(HEADER_W+NONCE_W)-1:0]    bloque_in,
  output logic [LANES-1:0]                       lane_load,
  output logic [CNT_W-1:0]                       counter,
  output logic                                   busy,
  output logic                                   done
);

  localparam int BLK_W = HEADER_W + NONCE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [HEADER_W-1:0]  hdr;
  logic [NONCE_W-1:0]   next_nonce;
  logic [NONCE_W-1:0]   last_nonce;
  logic [CNT_W-1:0]     last_phase;

  logic [LANES-1:0]     load_vec;
  logic [NONCE_W-1:0]   nonce_at [LANES];
  logic [NONCE_W-1:0]   nonce_nxt;
  logic                 hit_last;
  logic [CNT_W-1:0]     counter_inc;
  logic                 accept;
  logic                 drain_end;

  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && start && !stop;
  assign drain_end = (state == DRAIN) && !stop && (counter == last_phase);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Lanes are scanned in index order so that, once the final nonce is handed
  // out, no later lane in the same cycle or pass picks up another one.
  always_comb begin
    state_nxt   = state;
    load_vec    = '0;
    nonce_nxt   = next_nonce;
    hit_last    = 1'b0;
    counter_inc = (counter == CNT_W'(PERIOD - 1)) ? '0 : counter + 1'b1;
    for (int i = 0; i < LANES; i++) nonce_at[i] = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (!hit_last && (counter == CNT_W'(i * STAGGER))) begin
              load_vec[i] = 1'b1;
              nonce_at[i] = nonce_nxt;
              if (nonce_nxt == last_nonce) hit_last = 1'b1;
              nonce_nxt = nonce_nxt + 1'b1;
            end
          end
          if (hit_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (stop || drain_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hdr        <= '0;
      next_nonce <= '0;
      last_nonce <= '0;
      last_phase <= '0;
      counter    <= '0;
      lane_load  <= '0;
      done       <= 1'b0;
      bloque_in  <= '0;
    end else begin
      lane_load <= load_vec;
      done      <= drain_end;
      if (state == IDLE || state_nxt == IDLE) counter <= '0;
      else                                    counter <= counter_inc;
      if (accept) begin
        hdr        <= header;
        next_nonce <= nonce_base;
        last_nonce <= nonce_last;
      end
      if (state == RUN && !stop) next_nonce <= nonce_nxt;
      if (hit_last) last_phase <= counter;
      for (int i = 0; i < LANES; i++) begin
        if (load_vec[i]) bloque_in[i*BLK_W +: BLK_W] <= {hdr, nonce_at[i]};
      end
    end
  end

endmodule

// File: doc/concatenador_multi.md
# concatenador_multi

Parametrised multi-lane block assembler for the hash pipeline. Takes a job (header plus nonce range), generates its own phase counter, and loads each hash lane with a `{header, nonce}` block at that lane's staggered phase. The nonce auto-increments on every lane load until the range is exhausted, then the block drains and signals completion. It sits between the job source and the parallel hash cores, and also drives their round counter.

## Interface

Parameters:
- `HEADER_W`, 96, header width.
- `NONCE_W`, 32, nonce width; block width `BLK_W = HEADER_W + NONCE_W`.
- `LANES`, 2, number of hash lanes, at least 1.
- `PERIOD`, 64, cycles per hash pass; `counter` wraps `PERIOD-1 -> 0`.
- `STAGGER`, 2, phase offset between consecutive lanes; must satisfy `(LANES-1)*STAGGER < PERIOD`.
- `CNT_W`, `clog2(PERIOD)`, counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_L`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: job request; sampled only in IDLE.
- `stop`, in, 1: abort; has priority over `start`.
- `header`, in, `HEADER_W`: captured on an accepted `start`.
- `nonce_base`, in, `NONCE_W`: first nonce; captured on an accepted `start`.
- `nonce_last`, in, `NONCE_W`: final nonce, inclusive; captured on an accepted `start`.
- `bloque_in`, out, `LANES*BLK_W`: lane i occupies `[i*BLK_W +: BLK_W]`, laid out as `{header, nonce}`.
- `lane_load`, out, `LANES`: bit i pulses for 1 cycle, aligned with new lane i data.
- `counter`, out, `CNT_W`: phase counter for the hash cores.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: 1-cycle completion pulse.

## Operation

States are IDLE, RUN and DRAIN.

- **IDLE**
  - `counter` = 0.
  - `start=1` and `stop=0`: capture `header`, `nonce_base` and `nonce_last`; set `next_nonce = nonce_base`; go to RUN.
- **RUN**
  - `counter` increments modulo `PERIOD`.
  - When `counter == i*STAGGER`, lane i loads `{hdr, next_nonce}`, `next_nonce` increments modulo 2^`NONCE_W`, and `lane_load[i]` fires.
  - Lanes always load in index order.
  - When the loaded nonce equals `nonce_last`, record `last_phase = counter` and go to DRAIN. No further loads occur, so later lanes in that pass keep their old contents.
- **DRAIN**
  - `counter` keeps running.
  - When `counter` returns to `last_phase` (`PERIOD` cycles after the last load), go to IDLE and `counter` goes to 0.
  - `done` pulses in the first IDLE cycle.
- **stop**
  - In RUN or DRAIN: go to IDLE next cycle, no `done`, `counter` = 0.
  - `bloque_in` holds its values.
  - `lane_load` pulses already registered are not retracted.

Range rules:
- Range size is `nonce_last - nonce_base + 1` modulo 2^`NONCE_W`.
- A range with `nonce_last < nonce_base` wraps through all-ones to zero.
- `nonce_base == nonce_last` gives exactly one load, on lane 0.
- Termination is by equality only. The full 2^`NONCE_W` range is unsupported.

Other rules:
- `start` while busy is ignored; `start` and `stop` together in IDLE are ignored.
- Captured job values are frozen until the next accepted `start`.

## Timing

- Reset (asynchronous assert): IDLE; `bloque_in`, `lane_load`, `counter`, `busy`, `done` and all internal registers = 0.
- `start` accepted in cycle T:
  - `busy=1` and `counter=0` in T+1.
  - Lane i data and `lane_load[i]` are visible in T+2+i*`STAGGER`.
  - Subsequent passes follow every `PERIOD` cycles.
- Loads are registered: data and pulse change on the edge ending the cycle in which `counter == i*STAGGER`.
- `done`: last load sampled at counter phase p in cycle L gives `done=1` and `busy=0` in cycle L+`PERIOD`+1, with `counter=0` in that same cycle.
- `stop` in cycle S: `busy=0` and `counter=0` in S+1.
- A new `start` is accepted in the `done` cycle.
- Reset asserted mid-job clears everything immediately. After deassertion the block sits in IDLE; no `done` is issued for the aborted job.

## Test plan

1. **Basic range** (`LANES=2`, `PERIOD=64`, `STAGGER=2`, header `0xA5..A5`, base `0x10`, last `0x13`, start at cycle 0):
   - nonce `0x10` on lane 0 at cycle 2 and `0x11` on lane 1 at cycle 4;
   - `0x12` on lane 0 at cycle 66 and `0x13` on lane 1 at cycle 68;
   - `done` at cycle 132; exactly 4 `lane_load` pulses.
2. **Single nonce** (base = last = `0x5`): only `lane_load[0]` fires, at cycle 2; lane 1 stays 0; `done` at cycle 66.
3. **Wrap-around** (base `0xFFFFFFFF`, last `0x00000000`):
   - lane 0 gets `0xFFFFFFFF` and lane 1 gets `0x00000000`;
   - DRAIN begins after lane 1; no third load occurs.
4. **Abort** (`stop` at cycle 40 of test 1):
   - `busy=0` and `counter=0` at cycle 41;
   - `bloque_in` keeps `0x10`/`0x11`; no `done`; no further `lane_load`.
5. **Start while busy** (second `start` with a different header at cycle 10 of test 1): ignored; headers and nonces match test 1 exactly.
6. **Async reset** (`reset_L` pulled low at cycle 50 between clock edges): all outputs are 0 before the next rising edge; a new `start` after release behaves as in test 1.
